// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges stall requests, times a post-jump
// flush window and hands the RIB bus to an external master after draining.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_clint_i,
  input  logic        jtag_halt_i,
  input  logic        rib_req_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        rib_gnt_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, GRANT} state_e;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [3:0] FLUSH_LOAD = 4'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       level_stall;

  assign level_stall = hold_ex_i | hold_clint_i | jtag_halt_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        // Jump wins; a pending rib_req_i is picked up once back in RUN.
        if (jump_flag_i && (FLUSH_CYCLES != 0)) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (rib_req_i) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      FLUSH: begin
        if (jump_flag_i) begin
          cnt_d = FLUSH_LOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRAIN: begin
        if (!rib_req_i) begin
          state_d = RUN;
        end else if (jump_flag_i) begin
          cnt_d = DRAIN_LOAD;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!level_stall) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!rib_req_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign gnt_d  = (state_d == GRANT);
  assign busy_d = (state_d != RUN);

  always_comb begin
    hold_flag_o = HOLD_NONE;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    if (!rst) begin
      if (jump_flag_i || level_stall || (state_q == FLUSH)) begin
        hold_flag_o = HOLD_ID;
      end else if ((state_q == DRAIN) || (state_q == GRANT)) begin
        hold_flag_o = HOLD_PC;
      end
      if (state_q != GRANT) begin
        jump_flag_o = jump_flag_i;
        jump_addr_o = jump_addr_i;
      end
    end
  end

  assign rib_gnt_o = gnt_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: directed scenarios and random traffic compared
// cycle by cycle against a remaining-cycles model of the controller.
module tb_pipe_hold_ctrl;

  localparam int FLUSH_N = 1;
  localparam int DRAIN_N = 3;

  logic        clk, rst;
  logic        jump_flag_i, hold_ex_i, hold_clint_i, jtag_halt_i, rib_req_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o, rib_gnt_o, busy_o;
  logic [31:0] jump_addr_o;

  pipe_hold_ctrl #(.FLUSH_CYCLES(FLUSH_N), .DRAIN_CYCLES(DRAIN_N)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_clint_i(hold_clint_i),
    .jtag_halt_i(jtag_halt_i), .rib_req_i(rib_req_i),
    .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o),
    .jump_addr_o(jump_addr_o), .rib_gnt_o(rib_gnt_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int failed = 0;

  // Model: flush_rem = FLUSH cycles left incl. current; drain_rem = drain
  // cycles left before grant incl. current.
  int          flush_rem;
  int          drain_rem;
  bit          m_drain;
  bit          m_grant;
  logic [2:0]  exp_hold;
  logic        exp_jf, exp_gnt, exp_busy;
  logic [31:0] exp_addr;

  task automatic drive(input logic [5:0] v, input logic [31:0] addr);
    {rst, jump_flag_i, hold_ex_i, hold_clint_i, jtag_halt_i, rib_req_i} = v;
    jump_addr_i = addr;
    @(negedge clk);
    exp_gnt  = m_grant;
    exp_busy = (flush_rem > 0) || m_drain || m_grant;
    if (rst) begin
      exp_hold = 3'd0; exp_jf = 1'b0; exp_addr = '0;
    end else begin
      if (jump_flag_i || hold_ex_i || hold_clint_i || jtag_halt_i || flush_rem > 0)
        exp_hold = 3'd3;
      else if (m_drain || m_grant)
        exp_hold = 3'd1;
      else
        exp_hold = 3'd0;
      exp_jf   = m_grant ? 1'b0 : jump_flag_i;
      exp_addr = m_grant ? 32'd0 : jump_addr_i;
    end
  endtask

  task automatic advance();
    bit stall;
    stall = hold_ex_i || hold_clint_i || jtag_halt_i;
    if (rst) begin
      flush_rem = 0; drain_rem = 0; m_drain = 0; m_grant = 0;
    end else if (m_grant) begin
      if (!rib_req_i) m_grant = 0;
    end else if (m_drain) begin
      if (!rib_req_i) m_drain = 0;
      else if (jump_flag_i) drain_rem = DRAIN_N;
      else if (drain_rem > 1) drain_rem--;
      else if (!stall) begin m_drain = 0; m_grant = 1; end
    end else if (flush_rem > 0) begin
      if (jump_flag_i) flush_rem = FLUSH_N;
      else flush_rem--;
    end else begin
      if (jump_flag_i && FLUSH_N > 0) flush_rem = FLUSH_N;
      else if (rib_req_i) begin m_drain = 1; drain_rem = DRAIN_N; end
    end
    @(posedge clk);
    #1;
  endtask

  // Bit order of stimulus words: {rst, jump, ex, clint, jtag, req}
  task automatic test_reset();
    logic [5:0] seq [5];
    seq = '{6'b111111, 6'b111111, 6'b000000, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      drive(seq[i], 32'hFFFF_FFFF);
      tests++;
      if ({hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o} !==
          {exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy}) begin
        failed++;
        $display("FAIL reset c%0d: got h=%0d j=%b a=%h g=%b b=%b want h=%0d j=%b a=%h g=%b b=%b",
          i, hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o,
          exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy);
      end
      advance();
    end
  endtask

  task automatic test_jump();
    logic [5:0] seq [4];
    seq = '{6'b010000, 6'b000000, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      drive(seq[i], 32'h0000_0100);
      tests++;
      if ({hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o} !==
          {exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy}) begin
        failed++;
        $display("FAIL jump c%0d: got h=%0d j=%b a=%h g=%b b=%b want h=%0d j=%b a=%h g=%b b=%b",
          i, hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o,
          exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq [5];
    seq = '{6'b010000, 6'b010000, 6'b000000, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      drive(seq[i], $urandom);
      tests++;
      if ({hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o} !==
          {exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy}) begin
        failed++;
        $display("FAIL b2b c%0d: got h=%0d j=%b a=%h g=%b b=%b want h=%0d j=%b a=%h g=%b b=%b",
          i, hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o,
          exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy);
      end
      advance();
    end
  endtask

  task automatic test_grant();
    logic [5:0] seq [9];
    seq = '{6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000001,
            6'b011001, 6'b000000, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      drive(seq[i], $urandom);
      tests++;
      if ({hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o} !==
          {exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy}) begin
        failed++;
        $display("FAIL grant c%0d: got h=%0d j=%b a=%h g=%b b=%b want h=%0d j=%b a=%h g=%b b=%b",
          i, hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o,
          exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy);
      end
      advance();
    end
  endtask

  task automatic test_drain_abort_stall();
    logic [5:0] seq [15];
    seq = '{6'b000001, 6'b000001, 6'b000000, 6'b000000,
            6'b000001, 6'b000001, 6'b000001, 6'b001001, 6'b001001, 6'b001001,
            6'b000001, 6'b000101, 6'b000001, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      drive(seq[i], $urandom);
      tests++;
      if ({hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o} !==
          {exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy}) begin
        failed++;
        $display("FAIL drain c%0d: got h=%0d j=%b a=%h g=%b b=%b want h=%0d j=%b a=%h g=%b b=%b",
          i, hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o,
          exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy);
      end
      advance();
    end
  endtask

  task automatic test_jump_req();
    logic [5:0] seq [11];
    seq = '{6'b010001, 6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000001,
            6'b000001, 6'b100001, 6'b000001, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      drive(seq[i], $urandom);
      tests++;
      if ({hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o} !==
          {exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy}) begin
        failed++;
        $display("FAIL jreq c%0d: got h=%0d j=%b a=%h g=%b b=%b want h=%0d j=%b a=%h g=%b b=%b",
          i, hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o,
          exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic       req;
    logic [5:0] v;
    req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) req = ~req;
      v[5] = ($urandom_range(0, 63) == 0);
      v[4] = ($urandom_range(0, 7) == 0);
      v[3] = ($urandom_range(0, 5) == 0);
      v[2] = ($urandom_range(0, 11) == 0);
      v[1] = ($urandom_range(0, 11) == 0);
      v[0] = req;
      drive(v, $urandom);
      tests++;
      if ({hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o} !==
          {exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy}) begin
        failed++;
        $display("FAIL random c%0d: got h=%0d j=%b a=%h g=%b b=%b want h=%0d j=%b a=%h g=%b b=%b",
          i, hold_flag_o, jump_flag_o, jump_addr_o, rib_gnt_o, busy_o,
          exp_hold, exp_jf, exp_addr, exp_gnt, exp_busy);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0;
    hold_ex_i = 1'b0; hold_clint_i = 1'b0; jtag_halt_i = 1'b0; rib_req_i = 1'b0;
    flush_rem = 0; drain_rem = 0; m_drain = 0; m_grant = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_jump();
    test_back_to_back();
    test_grant();
    test_drain_abort_stall();
    test_jump_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
